uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Asynchronous serial transmitter, 8N1 by default, with optional parity and a second stop bit. It is the transmit counterpart of the team's UART receiver and shares its baud constants. A host presents a byte with a start/ready handshake. The block serialises it LSB-first on tx at a fixed bit period derived from the system clock. It sits between on-chip logic and the FPGA TX pin.

Parameters:
BAUD, 104, clock cycles per bit (104 = 115200 baud at 12 MHz); legal range >= 2
PARITY, 0, 0 = none, 1 = even, 2 = odd; other values are illegal
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  in  1  system clock; all logic on rising edge
rstn  in  1  reset, synchronous, active-low
start  in  1  request to send data; sampled only while ready=1
data  in  8  byte to send; sampled in the same cycle start is accepted
tx  out  1  serial line, idle high; driven from a flop (glitch-free)
ready  out  1  1 = idle, able to accept start; driven from a flop

Behaviour:
- Reset (rstn=0 at a clock edge): tx=1, ready=1, state=IDLE, baud counter=0, shift register cleared. Start is ignored while rstn=0.
- Reset mid-frame: the frame is abandoned. tx returns to 1 and ready to 1 on the cycle after the reset edge. No partial byte is resumed.
- Frame length F = 1 start + 8 data + (PARITY!=0 ? 1 : 0) + STOP_BITS bits. Each bit lasts exactly BAUD clocks.
- Acceptance: the cycle N edge where ready=1 and start=1.
  - At that edge, data is latched into the shift register {stop(s), parity?, data, 0}.
  - The parity bit is computed from the latched byte. Even: XOR of the 8 bits. Odd: its inverse.
  - Later changes to data do not affect the frame in flight.
- Timing from acceptance:
  - Cycles N+1 .. N+BAUD: tx=0 (start bit); ready=0 from N+1.
  - Bit k (k=0..F-1) occupies cycles N+1+k*BAUD .. N+(k+1)*BAUD.
  - Data bits go out LSB first, then parity, then the stop bit(s) with tx=1.
  - At cycle N+F*BAUD+1: state=IDLE, ready=1, tx=1.
- Back-to-back: start held high gives the next start bit at N+F*BAUD+2. This is a guaranteed minimum idle gap of 1 clock. No larger gap is inserted.
- start while ready=0 is ignored and not queued.
- FSM states:
  - IDLE: tx=1, ready=1. start moves it to TRANSMIT.
  - TRANSMIT: baud generator enabled; shift on each baud tick. After the tick that ends the last bit it moves to IDLE.
  - There is no separate stop state; stop bits are part of the shift register.
- Bit counter: 4 bits, counts ticks, and terminal count = F. Shift register width = F bits. On each tick it shifts right and fills with 1, so tx = shreg[0] registered.
- Baud generator:
  - Counter width is clog2(BAUD).
  - The counter is held at 0 when disabled. When enabled it counts 0..BAUD-1 and emits a 1-cycle tick when it reaches BAUD-1.
  - The first tick comes BAUD cycles after enable, so the start bit is full length.

Decomposition:
- Shared header/package:
  - Baud constants B300..B115200 for 12 MHz, the same values the receiver uses.
  - Parity encodings PAR_NONE/PAR_EVEN/PAR_ODD.
  - The state encodings IDLE/TRANSMIT.
- One sub-module: baudgen_tx. Inputs clk, rstn, clk_ena; output clk_out tick; parameter BAUD. It differs from the receiver's mid-bit-sampling generator by ticking at the end of the period.

Test Plan:
1. BAUD=4, PARITY=0, STOP_BITS=1: pulse start with data=0x55 at cycle N -> tx = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles over N+1..N+40; ready=0 over N+1..N+40 and 1 at N+41.
2. PARITY=1, data=0x07 -> parity bit 1 over cycles N+37..N+40, stop bit over N+41..N+44, ready=1 at N+45. Repeat with PARITY=2 -> parity bit 0.
3. STOP_BITS=2, data=0xA3 -> tx = 0, 1,1,0,0,0,1,0,1, then 1,1, i.e. 11 bits, 44 cycles; ready=1 at N+45.
4. start held high, data=0x00 then 0xFF -> second start bit (tx=0) begins exactly at N+42, frame 2 data bits all 1, ready high for exactly one cycle (N+41).
5. Pulse start again at N+10 with data=0xFF while the frame for 0x55 is in flight -> frame 1 unchanged, no second frame, ready=1 at N+41 and stays high.
6. rstn=0 at cycle N+15 mid-frame -> tx=1 and ready=1 from N+16; with rstn=1 and start=1 at N+20, a clean frame starts at N+21.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART constants: 12 MHz baud divisors (same values as the receiver),
// parity encodings, transmitter state encoding and frame-length helper.
package uart_tx_pkg;

    localparam int B300    = 40000;
    localparam int B1200   = 10000;
    localparam int B2400   = 5000;
    localparam int B4800   = 2500;
    localparam int B9600   = 1250;
    localparam int B19200  = 625;
    localparam int B38400  = 312;
    localparam int B57600  = 208;
    localparam int B115200 = 104;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } state_t;

    // start + 8 data + optional parity + stop bits
    function automatic int frame_len(input int parity, input int stop_bits);
        return 9 + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_baudgen.sv
// End-of-period bit tick for the transmitter: counts 0..BAUD-1 while enabled
// and pulses on BAUD-1, so the first tick lands a full bit after enable.
module baudgen_tx
    import uart_tx_pkg::*;
#(
    parameter int BAUD = B115200
) (
    input  logic clk,
    input  logic rstn,
    input  logic clk_ena,
    output logic clk_out
);

    localparam int W = (BAUD > 1) ? $clog2(BAUD) : 1;
    localparam logic [W-1:0] LAST = W'(BAUD - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (!clk_ena || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign clk_out = clk_ena && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start/ready handshake, LSB-first frame with optional
// parity and one or two stop bits, tx and ready both driven from flops.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | line high, ready=1, waiting for start
// TRANSMIT | shifting the frame out, one bit per baud tick (stop bits incl.)
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int BAUD      = B115200,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int F = frame_len(PARITY, STOP_BITS);
    localparam logic [3:0] F_TC = 4'(F);

    state_t       state, state_next;
    logic [F-1:0] shreg, shreg_next;
    logic [3:0]   bitcnt, bitcnt_next, bitcnt_inc;
    logic         tx_next, ready_next;
    logic         tick;
    logic         par_bit;
    logic [F-1:0] frame;

    baudgen_tx #(.BAUD(BAUD)) u_baudgen (
        .clk     (clk),
        .rstn    (rstn),
        .clk_ena (state == TRANSMIT),
        .clk_out (tick)
    );

    // Bits above the stop bit(s) are truncated away by the size cast.
    assign par_bit = (PARITY == PAR_ODD) ? ~^data : ^data;
    assign frame   = (PARITY == PAR_NONE) ? F'({3'b111, data, 1'b0})
                                          : F'({2'b11, par_bit, data, 1'b0});
    assign bitcnt_inc = bitcnt + 4'd1;

    always_comb begin
        state_next  = state;
        shreg_next  = shreg;
        bitcnt_next = bitcnt;
        tx_next     = tx;
        ready_next  = ready;
        case (state)
            IDLE: begin
                tx_next    = 1'b1;
                ready_next = 1'b1;
                if (start) begin
                    state_next  = TRANSMIT;
                    shreg_next  = frame;
                    bitcnt_next = '0;
                    tx_next     = frame[0];
                    ready_next  = 1'b0;
                end
            end
            TRANSMIT: begin
                tx_next = shreg[0];
                if (tick) begin
                    shreg_next  = {1'b1, shreg[F-1:1]};
                    tx_next     = shreg[1];
                    bitcnt_next = bitcnt_inc;
                    if (bitcnt_inc == F_TC) begin
                        state_next  = IDLE;
                        bitcnt_next = '0;
                        tx_next     = 1'b1;
                        ready_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            tx     <= 1'b1;
            ready  <= 1'b1;
        end else begin
            state  <= state_next;
            shreg  <= shreg_next;
            bitcnt <= bitcnt_next;
            tx     <= tx_next;
            ready  <= ready_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, even, odd, two stop bits) at BAUD=4,
// cycle-exact {tx,ready} expectations queued per instance at stimulus time.
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int BAUD = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] start;
    logic [3:0] tx;
    logic [3:0] ready;
    logic [7:0] data [4];

    logic [1:0] exp_q [4][$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    string      phase = "init";

    uart_tx #(.BAUD(BAUD), .PARITY(PAR_NONE), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rstn(rstn), .start(start[0]), .data(data[0]), .tx(tx[0]), .ready(ready[0]));
    uart_tx #(.BAUD(BAUD), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start[1]), .data(data[1]), .tx(tx[1]), .ready(ready[1]));
    uart_tx #(.BAUD(BAUD), .PARITY(PAR_ODD), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rstn(rstn), .start(start[2]), .data(data[2]), .tx(tx[2]), .ready(ready[2]));
    uart_tx #(.BAUD(BAUD), .PARITY(PAR_NONE), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rstn(rstn), .start(start[3]), .data(data[3]), .tx(tx[3]), .ready(ready[3]));

    always #5 clk = ~clk;

    function automatic int par_of(input int d);
        case (d)
            1:       return PAR_EVEN;
            2:       return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    function automatic int stop_of(input int d);
        return (d == 3) ? 2 : 1;
    endfunction

    function automatic bit pending();
        for (int d = 0; d < 4; d++)
            if (exp_q[d].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_idle(input int d, input int n);
        repeat (n) exp_q[d].push_back(2'b11);
    endtask

    // Expected {tx,ready} for every cycle from N+1 through the ready cycle.
    task automatic push_frame(input int d, input logic [7:0] b);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (par_of(d) == PAR_EVEN) bits.push_back(^b);
        if (par_of(d) == PAR_ODD)  bits.push_back(~^b);
        repeat (stop_of(d)) bits.push_back(1'b1);
        foreach (bits[i]) repeat (BAUD) exp_q[d].push_back({bits[i], 1'b0});
        exp_q[d].push_back(2'b11);
    endtask

    task automatic step();
        logic [1:0] got;
        logic [1:0] want;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 4; d++) begin
            if (exp_q[d].size() > 0) begin
                want = exp_q[d].pop_front();
                got  = {tx[d], ready[d]};
                vectors++;
                assert (got === want) else begin
                    miscompares++;
                    $error("FAIL %s dut%0d cycle N+%0d: tx,ready=%b required %b",
                           phase, d, cyc, got, want);
                end
            end
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (pending() && guard < 500) begin
            step();
            guard++;
        end
        vectors++;
        assert (guard < 500) else begin
            miscompares++;
            $error("FAIL %s drain: cycles=%0d required <500", phase, guard);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn  = 1'b0;
        start = 4'hF;
        for (int d = 0; d < 4; d++) data[d] = 8'hA5;

        phase = "reset";
        for (int d = 0; d < 4; d++) push_idle(d, 2);
        step();
        step();
        start = 4'h0;
        rstn  = 1'b1;
        for (int d = 0; d < 4; d++) push_idle(d, 2);
        step();
        step();

        phase = "frames";
        data[0] = 8'h55;
        data[1] = 8'h07;
        data[2] = 8'h07;
        data[3] = 8'hA3;
        start   = 4'hF;
        for (int d = 0; d < 4; d++) begin
            push_frame(d, data[d]);
            push_idle(d, 3);
        end
        cyc = 0;
        step();
        start = 4'h0;
        data[0] = 8'h00;
        data[3] = 8'hFF;
        drain();

        phase = "back_to_back";
        data[0]  = 8'h00;
        start[0] = 1'b1;
        push_frame(0, 8'h00);
        push_frame(0, 8'hFF);
        push_idle(0, 2);
        cyc = 0;
        step();
        data[0] = 8'hFF;
        repeat (44) step();
        start[0] = 1'b0;
        drain();

        phase = "busy_start";
        data[0]  = 8'h55;
        start[0] = 1'b1;
        push_frame(0, 8'h55);
        push_idle(0, 6);
        cyc = 0;
        step();
        start[0] = 1'b0;
        repeat (9) step();
        data[0]  = 8'hFF;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        drain();

        phase = "reset_mid";
        data[0]  = 8'h55;
        start[0] = 1'b1;
        push_frame(0, 8'h55);
        cyc = 0;
        step();
        start[0] = 1'b0;
        repeat (14) step();
        rstn = 1'b0;
        exp_q[0].delete();
        for (int d = 0; d < 4; d++) push_idle(d, 5);
        step();
        rstn = 1'b1;
        repeat (4) step();
        data[0]  = 8'h3C;
        start[0] = 1'b1;
        push_frame(0, 8'h3C);
        push_idle(0, 2);
        step();
        start[0] = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
